feeder_servo_dispenser: RTL
===========================

Name: feeder_servo_dispenser

Overview:
Consumer end of the button-to-processor command path. Reads command register 2 of the processor register file. A non-zero value (portion count 1-9) starts a dispense, and the block clears the register by writing 0 back through the register-file write port. It then drives the feeder servo PWM through one open/close cycle per portion. The servo is held closed while idle.

Parameters:
PWM_PERIOD, 1000000, clock cycles per servo frame (20 ms at 50 MHz)
CLOSED_PULSE, 50000, high-time cycles for the closed position (1 ms)
OPEN_PULSE, 100000, high-time cycles for the open position (2 ms)
OPEN_FRAMES, 25, frames held open per portion
CLOSED_FRAMES, 25, frames held closed between portions
CMD_REG, 2, register-file index of the command register

Ports:
clock  in  1  system clock
reset  in  1  synchronous, active-high reset
ctrlReadReg  out  5  register index read; constant CMD_REG
readReg  in  32  contents of register CMD_REG
ctrlWriteReg  out  5  register index written; constant CMD_REG
writeReg  out  32  write data; always 0
wren  out  1  one-cycle write strobe that clears the command register
pwm  out  1  servo control signal
busy  out  1  high while a dispense is in progress
portions_total  out  8  saturating count of completed portions

Behaviour:
- One clock. Reset is synchronous and active-high, sampled on the rising edge of clock.
- Reset values: state IDLE, frame_cnt 0, width_q CLOSED_PULSE, pwm 0, busy 0, wren 0, writeReg 0, portions_total 0, remaining 0.
- Reset mid-dispense aborts immediately, and the servo returns to closed pulses. The command register is not rewritten.

Frame counter:
- frame_cnt counts 0..PWM_PERIOD-1 and wraps. Width is $clog2(PWM_PERIOD).
- frame_last = (frame_cnt == PWM_PERIOD-1).
- pwm = (frame_cnt < width_q), driven from registers only.
- width_q is loaded only on frame_last: OPEN_PULSE if the next frame's state is OPEN, else CLOSED_PULSE. The pulse width therefore never changes mid-frame.

Command decode:
- cmd = readReg[3:0]. Values 10-15 clamp to 9.
- readReg[31:4] non-zero is treated as 9.
- readReg == 0 means no command.

State machine: IDLE, ACCEPT, SYNC, OPEN, CLOSE.
- IDLE: if readReg != 0, go to ACCEPT. The decoded count is latched into remaining in the same edge.
- ACCEPT: exactly 1 cycle. wren=1, writeReg=0. busy goes high on entry. Then go to SYNC.
- SYNC: wait for frame_last, then go to OPEN with frames_left = OPEN_FRAMES-1.
- OPEN: on each frame_last, decrement frames_left.
  - At 0: go to CLOSE with frames_left = CLOSED_FRAMES-1.
  - On that same edge, decrement remaining and increment portions_total (saturates at 255).
- CLOSE: on each frame_last, decrement frames_left.
  - At 0: go to OPEN if remaining != 0, else go to IDLE.
  - busy drops on the edge entering IDLE.
- Leaving IDLE requires a fresh non-zero readReg. A value written by the processor during busy stays in the register and is accepted after return to IDLE. No command is lost and none is accepted twice.

Timing:
- Latency from readReg becoming non-zero to wren is 1 cycle.
- The first open pulse starts at the first frame boundary after ACCEPT.
- The final CLOSE segment is always completed before IDLE, so the hopper ends closed.

Simultaneous events:
- A non-zero readReg arriving on the cycle busy falls is seen on the next IDLE cycle.
- Write arbitration against the button writer belongs to the register file and is not handled here. This block asserts wren only in ACCEPT.

Test Plan:
Shared configuration: PWM_PERIOD=100, CLOSED_PULSE=5, OPEN_PULSE=10, OPEN_FRAMES=2, CLOSED_FRAMES=2.
1. Reset then idle, readReg=0 for 500 cycles -> pwm high exactly 5 cycles per 100-cycle frame, busy=0, wren never asserted.
2. readReg=3 for one sample -> wren=1 with writeReg=0 exactly 1 cycle later. Then 3 open segments of 2 frames with 10-cycle pulses, each followed by 2 frames of 5-cycle pulses. portions_total=3, busy low after the last closed frame.
3. readReg=12 -> clamped: 9 open segments, portions_total=9.
4. readReg=2 accepted, then readReg=1 written during busy -> first dispense completes (2 portions). The value 1 is accepted on the next IDLE cycle, giving 1 more portion, portions_total=3.
5. readReg=4, reset asserted during the 2nd open frame -> next cycle pwm=0, busy=0, portions_total=0. After reset is released, 5-cycle closed pulses resume.
6. Width check: issue a command mid-frame at frame_cnt=50 -> no pulse longer than 5 cycles in that frame. The first 10-cycle pulse starts at the next frame_cnt=0.

Source files
------------

// File: rtl/feeder_servo_dispenser.sv
// Feeder servo dispenser: takes a portion count from a register-file command register, clears it, and cycles the servo.
// Latency: wren one cycle after readReg goes non-zero; first open pulse starts at the next frame boundary after accept.
// Backpressure: none; a command written while busy stays in the register and is accepted on the next IDLE cycle.
module feeder_servo_dispenser #(
  parameter int PWM_PERIOD    = 1000000,
  parameter int CLOSED_PULSE  = 50000,
  parameter int OPEN_PULSE    = 100000,
  parameter int OPEN_FRAMES   = 25,
  parameter int CLOSED_FRAMES = 25,
  parameter int CMD_REG       = 2
) (
  input  logic        clock,
  input  logic        reset,
  output logic [4:0]  ctrlReadReg,
  input  logic [31:0] readReg,
  output logic [4:0]  ctrlWriteReg,
  output logic [31:0] writeReg,
  output logic        wren,
  output logic        pwm,
  output logic        busy,
  output logic [7:0]  portions_total
);

  localparam int CW   = $clog2(PWM_PERIOD);
  localparam int WW   = CW + 1;
  localparam int MAXF = (OPEN_FRAMES > CLOSED_FRAMES) ? OPEN_FRAMES : CLOSED_FRAMES;
  localparam int FW   = (MAXF > 1) ? $clog2(MAXF) : 1;

  localparam logic [CW-1:0] FRAME_MAX   = CW'(PWM_PERIOD - 1);
  localparam logic [WW-1:0] OPEN_W      = WW'(OPEN_PULSE);
  localparam logic [WW-1:0] CLOSED_W    = WW'(CLOSED_PULSE);
  localparam logic [FW-1:0] OPEN_LAST   = FW'(OPEN_FRAMES - 1);
  localparam logic [FW-1:0] CLOSED_LAST = FW'(CLOSED_FRAMES - 1);

  typedef enum logic [2:0] {
    S_IDLE,
    S_ACCEPT,
    S_SYNC,
    S_OPEN,
    S_CLOSE
  } state_t;

  state_t        state_q, state_d;
  logic [CW-1:0] frame_cnt_q, frame_cnt_d;
  logic [WW-1:0] width_q, width_d;
  logic          pwm_q;
  logic [FW-1:0] frames_left_q, frames_left_d;
  logic [3:0]    remaining_q, remaining_d;
  logic [7:0]    total_q, total_d;
  logic          frame_last;
  logic [3:0]    cmd_cnt;

  assign frame_last = (frame_cnt_q == FRAME_MAX);

  // Decode the portion count: anything above 9, including high bits set, clamps to 9.
  always_comb begin
    cmd_cnt = readReg[3:0];
    if ((readReg[31:4] != 28'd0) || (readReg[3:0] > 4'd9)) begin
      cmd_cnt = 4'd9;
    end
  end

  // Next-state logic: dispense sequencing, frame counting and the frame-aligned pulse width.
  always_comb begin
    state_d       = state_q;
    frames_left_d = frames_left_q;
    remaining_d   = remaining_q;
    total_d       = total_q;
    frame_cnt_d   = frame_last ? '0 : frame_cnt_q + 1'b1;

    case (state_q)
      S_IDLE: begin
        if (readReg != 32'd0) begin
          state_d     = S_ACCEPT;
          remaining_d = cmd_cnt;
        end
      end
      S_ACCEPT: begin
        state_d = S_SYNC;
      end
      S_SYNC: begin
        if (frame_last) begin
          state_d       = S_OPEN;
          frames_left_d = OPEN_LAST;
        end
      end
      S_OPEN: begin
        if (frame_last) begin
          if (frames_left_q == '0) begin
            state_d       = S_CLOSE;
            frames_left_d = CLOSED_LAST;
            remaining_d   = remaining_q - 1'b1;
            if (total_q != 8'hFF) begin
              total_d = total_q + 1'b1;
            end
          end else begin
            frames_left_d = frames_left_q - 1'b1;
          end
        end
      end
      S_CLOSE: begin
        if (frame_last) begin
          if (frames_left_q == '0) begin
            if (remaining_q != 4'd0) begin
              state_d       = S_OPEN;
              frames_left_d = OPEN_LAST;
            end else begin
              state_d = S_IDLE;
            end
          end else begin
            frames_left_d = frames_left_q - 1'b1;
          end
        end
      end
      default: begin
        state_d = S_IDLE;
      end
    endcase

    // Width only changes at a frame boundary so no pulse is ever stretched or cut.
    width_d = width_q;
    if (frame_last) begin
      width_d = (state_d == S_OPEN) ? OPEN_W : CLOSED_W;
    end
  end

  // State and datapath registers; reset aborts any dispense and parks the servo closed.
  always_ff @(posedge clock) begin
    if (reset) begin
      state_q       <= S_IDLE;
      frame_cnt_q   <= '0;
      width_q       <= CLOSED_W;
      pwm_q         <= 1'b0;
      frames_left_q <= '0;
      remaining_q   <= 4'd0;
      total_q       <= 8'd0;
    end else begin
      state_q       <= state_d;
      frame_cnt_q   <= frame_cnt_d;
      width_q       <= width_d;
      pwm_q         <= ({1'b0, frame_cnt_q} < width_q);
      frames_left_q <= frames_left_d;
      remaining_q   <= remaining_d;
      total_q       <= total_d;
    end
  end

  assign ctrlReadReg    = 5'(CMD_REG);
  assign ctrlWriteReg   = 5'(CMD_REG);
  assign writeReg       = 32'd0;
  assign wren           = (state_q == S_ACCEPT);
  assign busy           = (state_q != S_IDLE);
  assign pwm            = pwm_q;
  assign portions_total = total_q;

endmodule
